fulladder_checker: RTL and testbench

FULLADDER_CHECKER -- requirements
Module: fulladder_checker

---
 rtl/fa_check_pkg.sv | 20 ++
 rtl/fa_ref_model.sv | 13 +
 rtl/fulladder_checker.sv | 141 ++++++++++++++
 tb/tb_fulladder_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_check_pkg.sv
// rtl/fa_check_pkg.sv - shared types and constants for the full-adder checker
package fa_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int COMBO_CNT = 8;

    // One-hot coverage bit for input combination {c,b,a}
    function automatic logic [COMBO_CNT-1:0] combo_bit(input logic a, input logic b, input logic c);
        logic [COMBO_CNT-1:0] v;
        v = '0;
        v[{c, b, a}] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fa_ref_model.sv
// rtl/fa_ref_model.sv - golden combinational full adder used as the reference
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_sum,
    output logic exp_carry
);

    assign exp_sum   = a ^ b ^ c;
    assign exp_carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fulladder_checker.sv
// rtl/fulladder_checker.sv - checks an external full adder, tracks coverage and errors per run
module fulladder_checker
    import fa_check_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             sum,
    input  logic             carry,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       covered,
    output logic [2:0]       first_fail_vec,
    output logic             fail_seen,
    output logic             done,
    output logic             pass,
    output logic             timeout
);

    localparam int CYC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [ERR_W-1:0]       err_count_q, err_count_d;
    logic [COMBO_CNT-1:0]   covered_q, covered_d;
    logic [2:0]             first_fail_vec_q, first_fail_vec_d;
    logic                   fail_seen_q, fail_seen_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;

    logic exp_sum;
    logic exp_carry;
    logic mismatch;

    fa_ref_model u_ref (
        .a         (a),
        .b         (b),
        .c         (c),
        .exp_sum   (exp_sum),
        .exp_carry (exp_carry)
    );

    assign mismatch = (sum != exp_sum) || (carry != exp_carry);

    always_comb begin
        state_d          = state_q;
        err_count_d      = err_count_q;
        covered_d        = covered_q;
        first_fail_vec_d = first_fail_vec_q;
        fail_seen_d      = fail_seen_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        cyc_d            = cyc_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = RUN;
                    err_count_d      = '0;
                    covered_d        = '0;
                    first_fail_vec_d = '0;
                    fail_seen_d      = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    cyc_d            = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (sample_en) begin
                    covered_d = covered_q | combo_bit(a, b, c);
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!fail_seen_q) begin
                            fail_seen_d      = 1'b1;
                            first_fail_vec_d = {c, b, a};
                        end
                    end
                end
                // Completing coverage wins over a timeout on the same edge
                if (covered_d == '1) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    pass_d    = (err_count_d == '0);
                    timeout_d = 1'b0;
                end else if (cyc_q == CYC_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            err_count_q      <= '0;
            covered_q        <= '0;
            first_fail_vec_q <= '0;
            fail_seen_q      <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            cyc_q            <= '0;
        end else begin
            state_q          <= state_d;
            err_count_q      <= err_count_d;
            covered_q        <= covered_d;
            first_fail_vec_q <= first_fail_vec_d;
            fail_seen_q      <= fail_seen_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            cyc_q            <= cyc_d;
        end
    end

    assign err_count      = err_count_q;
    assign covered        = covered_q;
    assign first_fail_vec = first_fail_vec_q;
    assign fail_seen      = fail_seen_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_fulladder_checker.sv
// tb/tb_fulladder_checker.sv - directed bench for fulladder_checker with a behavioural run model
module tb_fulladder_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sample_en = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic sum = 1'b0;
    logic carry = 1'b0;

    logic [7:0] err0;
    logic [7:0] cov0;
    logic [2:0] ffv0;
    logic       fs0, dn0, ps0, to0;
    logic [1:0] err1;
    logic [7:0] cov1;
    logic [2:0] ffv1;
    logic       fs1, dn1, ps1, to1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: short timeout, wide counter. Instance 1: default timeout, 2-bit counter.
    fulladder_checker #(.TIMEOUT_CYCLES(16), .ERR_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .err_count(err0), .covered(cov0), .first_fail_vec(ffv0),
        .fail_seen(fs0), .done(dn0), .pass(ps0), .timeout(to0)
    );

    fulladder_checker #(.TIMEOUT_CYCLES(1024), .ERR_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .err_count(err1), .covered(cov1), .first_fail_vec(ffv1),
        .fail_seen(fs1), .done(dn1), .pass(ps1), .timeout(to1)
    );

    // Behavioural model: 0 idle, 1 running, 2 finished
    int m_state[2] = '{0, 0};
    int m_err[2]   = '{0, 0};
    int m_cyc[2]   = '{0, 0};
    int m_ffv[2]   = '{0, 0};
    bit m_fs[2]    = '{0, 0};
    bit m_done[2]  = '{0, 0};
    bit m_pass[2]  = '{0, 0};
    bit m_to[2]    = '{0, 0};
    bit m_seen[2][8];

    task automatic model_clear(input int k);
        m_err[k] = 0; m_cyc[k] = 0; m_ffv[k] = 0; m_fs[k] = 0;
        m_done[k] = 0; m_pass[k] = 0; m_to[k] = 0;
        for (int i = 0; i < 8; i++) m_seen[k][i] = 0;
    endtask

    task automatic model_step(input int k, input int tmo, input int errmax);
        int idx, tot, nseen;
        if (m_state[k] == 1) begin
            if (sample_en) begin
                idx = int'(a) + 2 * int'(b) + 4 * int'(c);
                tot = int'(a) + int'(b) + int'(c);
                m_seen[k][idx] = 1;
                if ((int'(sum) != tot % 2) || (int'(carry) != (tot >= 2 ? 1 : 0))) begin
                    if (m_err[k] < errmax) m_err[k] = m_err[k] + 1;
                    if (!m_fs[k]) begin
                        m_fs[k] = 1;
                        m_ffv[k] = idx;
                    end
                end
            end
            nseen = 0;
            for (int i = 0; i < 8; i++) nseen += int'(m_seen[k][i]);
            if (nseen == 8) begin
                m_state[k] = 2; m_done[k] = 1; m_pass[k] = (m_err[k] == 0); m_to[k] = 0;
            end else if (m_cyc[k] == tmo - 1) begin
                m_state[k] = 2; m_done[k] = 1; m_pass[k] = 0; m_to[k] = 1;
            end
            m_cyc[k] = m_cyc[k] + 1;
        end else if (start) begin
            model_clear(k);
            m_state[k] = 1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                model_clear(k);
                m_state[k] = 0;
            end
        end else begin
            model_step(0, 16, 255);
            model_step(1, 1024, 3);
        end
    end

    function automatic logic [31:0] model_vec(input int k);
        logic [7:0] cv;
        for (int i = 0; i < 8; i++) cv[i] = m_seen[k][i];
        return {9'b0, m_done[k], m_pass[k], m_to[k], m_fs[k], m_ffv[k][2:0], cv, m_err[k][7:0]};
    endfunction

    logic [31:0] act0, act1, exp0, exp1;

    always @(negedge clk) begin
        act0 = {9'b0, dn0, ps0, to0, fs0, ffv0, cov0, err0};
        act1 = {9'b0, dn1, ps1, to1, fs1, ffv1, cov1, 6'b0, err1};
        exp0 = model_vec(0);
        exp1 = model_vec(1);
        checks++;
        if (act0 !== exp0) begin
            failures++;
            $display("FAIL model_inst0 t=%0t act=%h exp=%h", $time, act0, exp0);
        end
        checks++;
        if (act1 !== exp1) begin
            failures++;
            $display("FAIL model_inst1 t=%0t act=%h exp=%h", $time, act1, exp1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle_cyc();
        start = 0; sample_en = 0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1; sample_en = 0;
        @(negedge clk);
        start = 0;
    endtask

    // fault: 0 good adder, 1 carry stuck-at-0, 2 sum inverted
    task automatic samp(input int v, input int fault);
        int tot;
        tot = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
        start = 0; sample_en = 1;
        a = v[0]; b = v[1]; c = v[2];
        sum = (tot % 2) == 1;
        carry = tot >= 2;
        if (fault == 1) carry = 0;
        if (fault == 2) sum = ~sum;
        @(negedge clk);
        sample_en = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_err", 32'(err0), 0);
        chk("rst_cov", 32'(cov0), 0);
        chk("rst_flags", {28'b0, dn0, ps0, to0, fs0}, 0);
        reset = 0;
        idle_cyc();

        // Good adder, full sweep
        pulse_start();
        for (int v = 0; v < 7; v++) samp(v, 0);
        chk("good_not_done_7", 32'(dn0), 0);
        samp(7, 0);
        chk("good_cov", 32'(cov0), 32'hFF);
        chk("good_err", 32'(err0), 0);
        chk("good_done_pass_to", {29'b0, dn0, ps0, to0}, 32'b110);

        // Carry stuck-at-0; start in DONE clears status
        pulse_start();
        chk("restart_cov", 32'(cov0), 0);
        chk("restart_done", 32'(dn0), 0);
        for (int v = 0; v < 8; v++) samp(v, 1);
        chk("stuck_err", 32'(err0), 4);
        chk("stuck_ffv", 32'(ffv0), 3);
        chk("stuck_fs", 32'(fs0), 1);
        chk("stuck_done_pass", {30'b0, dn0, ps0}, 32'b10);

        // Timeout on instance 0 after RUN edge 16
        pulse_start();
        for (int v = 0; v < 7; v++) samp(v, 0);
        repeat (8) idle_cyc();
        chk("tmo_not_done_15", 32'(dn0), 0);
        idle_cyc();
        chk("tmo_done_to", {30'b0, dn0, to0}, 32'b11);
        chk("tmo_cov", 32'(cov0), 32'h7F);
        chk("tmo_pass", 32'(ps0), 0);
        samp(7, 0);
        chk("tmo_done_ignores_sample", 32'(cov0), 32'h7F);
        chk("inst1_done_no_to", {30'b0, dn1, to1}, 32'b10);

        // Reset mid-run abandons everything
        pulse_start();
        samp(3, 1); samp(5, 1); samp(1, 0);
        chk("mid_fs_before_rst", 32'(fs0), 1);
        reset = 1;
        #2;
        chk("mid_rst_async", {16'b0, cov0, err0}, 0);
        idle_cyc();
        chk("mid_rst_flags", {25'b0, ffv0, dn0, ps0, to0, fs0}, 0);
        reset = 0;
        samp(2, 0); samp(6, 0);
        chk("idle_sample_ignored", 32'(cov0), 0);
        chk("idle_stays", 32'(dn0), 0);
        pulse_start();
        for (int v = 0; v < 8; v++) samp(v, 0);
        chk("after_rst_pass", {30'b0, dn0, ps0}, 32'b11);

        // Saturation and start ignored in RUN
        pulse_start();
        for (int i = 0; i < 6; i++) samp(1, 2);
        chk("sat_err1", 32'(err1), 3);
        chk("sat_err0", 32'(err0), 6);
        chk("sat_ffv", 32'(ffv1), 1);
        pulse_start();
        chk("run_start_ignored_cov", 32'(cov0), 32'h02);
        chk("run_start_ignored_err", 32'(err0), 6);
        for (int v = 0; v < 8; v++) samp(v, 0);
        chk("sat_final", {30'b0, dn1, ps1}, 32'b10);
        chk("sat_final_err1", 32'(err1), 3);

        // Coverage completes on the timeout edge: coverage wins
        pulse_start();
        chk("clear_all", {14'b0, ffv0, cov0, err0, fs0, dn0, ps0, to0}, 0);
        for (int v = 0; v < 7; v++) samp(v, 0);
        repeat (8) idle_cyc();
        chk("edge_not_done_15", 32'(dn0), 0);
        samp(7, 0);
        chk("edge_cov_wins", {29'b0, dn0, ps0, to0}, 32'b110);

        repeat (2) idle_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
